// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// regfile_sequencer : initiator for a three-bus register file (A/B read, D write)
// Optional watchdog in EXEC: define REGSEQ_TIMEOUT_EN.            Rev 1.0
// ============================================================================
module regfile_sequencer #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 5,
    parameter int READ_WAIT      = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              opValid,
    output logic              opReady,
    input  logic [ADDR_W-1:0] opSrcA,
    input  logic [ADDR_W-1:0] opSrcB,
    input  logic [ADDR_W-1:0] opDst,
    input  logic              opUseA,
    input  logic              opUseB,
    input  logic              opWrite,
    output logic [DATA_W-1:0] operandA,
    output logic [DATA_W-1:0] operandB,
    output logic              operandValid,
    input  logic [DATA_W-1:0] result,
    input  logic              resultValid,
    output logic [ADDR_W-1:0] regAddrA,
    output logic [ADDR_W-1:0] regAddrB,
    output logic [ADDR_W-1:0] regAddrD,
    output logic              regReA,
    output logic              regReB,
    output logic              regWeD,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    output logic [DATA_W-1:0] busD,
    output logic              opDone,
    output logic              opErr
);

    localparam int c_RW_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_EXEC    = 3'd3,
        S_SETUP   = 3'd4,
        S_WRITE   = 3'd5,
        S_HOLD    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_srcA;
    logic [ADDR_W-1:0]   r_srcB;
    logic [ADDR_W-1:0]   r_dst;
    logic                r_useA;
    logic                r_useB;
    logic                r_write;
    logic [c_RW_W-1:0]   r_rdCnt;
    logic [DATA_W-1:0]   r_opA;
    logic [DATA_W-1:0]   r_opB;
    logic [DATA_W-1:0]   r_busD;
    logic [ADDR_W-1:0]   r_addrD;

    logic                w_accept;
    logic                w_rdLast;
    logic                w_wb;
    logic                w_timeout;
    logic                w_err;
    logic [DATA_W-1:0]   w_capA;
    logic [DATA_W-1:0]   w_capB;

    // Empty on legal settings; kept so both parameters are always elaborated.
    if (READ_WAIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_range
    end

    assign w_accept = opValid && (r_state == S_IDLE);
    assign w_rdLast = (!r_useA && !r_useB) || (r_rdCnt == c_RW_W'(READ_WAIT - 1));
    assign w_wb     = r_write && (r_dst != '0);
    assign w_capA   = r_useA ? busA : '0;
    assign w_capB   = r_useB ? busB : '0;

    // Operands are presented live from the buses during CAPTURE so they line
    // up with the operandValid pulse, then held from the capture registers.
    assign operandA = (r_state == S_CAPTURE) ? w_capA : r_opA;
    assign operandB = (r_state == S_CAPTURE) ? w_capB : r_opB;
    assign regAddrA = r_srcA;
    assign regAddrB = r_srcB;
    assign regAddrD = r_addrD;
    assign busD     = r_busD;

`ifdef REGSEQ_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo;
    logic               r_err;

    assign w_timeout = (r_state == S_EXEC) && !resultValid
                       && (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_err     = r_err;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_CAPTURE) begin
                r_tmo <= '0;
            end else if (r_state == S_EXEC) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end
            if (r_state == S_EXEC) begin
                r_err <= w_timeout;
            end else if (r_state == S_DONE) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        opReady      = 1'b0;
        regReA       = 1'b0;
        regReB       = 1'b0;
        regWeD       = 1'b0;
        operandValid = 1'b0;
        opDone       = 1'b0;
        opErr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                opReady = 1'b1;
                if (opValid) w_next = S_READ;
            end
            S_READ: begin
                regReA = r_useA;
                regReB = r_useB;
                if (w_rdLast) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                operandValid = 1'b1;
                w_next       = S_EXEC;
            end
            S_EXEC: begin
                if (resultValid) begin
                    w_next = w_wb ? S_SETUP : S_DONE;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_SETUP: w_next = S_WRITE;
            S_WRITE: begin
                regWeD = 1'b1;
                w_next = S_HOLD;
            end
            S_HOLD:  w_next = S_DONE;
            S_DONE: begin
                opDone = !w_err;
                opErr  = w_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
            r_srcA  <= '0;
            r_srcB  <= '0;
            r_dst   <= '0;
            r_useA  <= 1'b0;
            r_useB  <= 1'b0;
            r_write <= 1'b0;
            r_rdCnt <= '0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_busD  <= '0;
            r_addrD <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_srcA  <= opSrcA;
                r_srcB  <= opSrcB;
                r_dst   <= opDst;
                r_useA  <= opUseA;
                r_useB  <= opUseB;
                r_write <= opWrite;
                r_rdCnt <= '0;
            end
            if (r_state == S_READ && !w_rdLast) begin
                r_rdCnt <= r_rdCnt + c_RW_W'(1);
            end
            if (r_state == S_CAPTURE) begin
                r_opA <= w_capA;
                r_opB <= w_capB;
            end
            // Write address only moves for a real writeback, so it keeps
            // its last value across reads and register-0 writes.
            if (r_state == S_EXEC && resultValid) begin
                r_busD <= result;
                if (w_wb) r_addrD <= r_dst;
            end
        end
    end

endmodule
`default_nettype wire
